ahb2apb_bridge: RTL
===================

Name: ahb2apb_bridge

Overview:
- AHB-Lite slave to APB master bridge; the stage directly upstream of the APB bus that the APB VIP monitors and responds to.
- Converts each accepted AHB-Lite single transfer into one APB SETUP/ACCESS sequence.
- Stalls the AHB data phase via hreadyout until the APB transfer completes, then returns read data and error status.

Parameters:
- AHB_AW, 32, AHB address width
- APB_AW, 32, APB address width (APB_AW <= AHB_AW); paddr = haddr[APB_AW-1:0]
- DW, 32, data width on both buses

Ports:
- clk  in  1  single clock for both buses
- reset_n  in  1  reset, synchronous, active-low
- hsel  in  1  AHB slave select
- haddr  in  AHB_AW  AHB address
- htrans  in  2  AHB transfer type; bit 1 set = NONSEQ/SEQ
- hwrite  in  1  AHB write
- hwdata  in  DW  AHB write data, valid in data phase
- hready_in  in  1  system HREADY
- hreadyout  out  1  slave ready
- hrdata  out  DW  read data
- hresp  out  1  1 = ERROR
- paddr  out  APB_AW  APB address
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- pwdata  out  DW  APB write data
- prdata  in  DW  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB error; tie 0 if unused

Behaviour:
- Reset: synchronous; reset_n=0 sampled at a clk edge forces state IDLE. Outputs after that edge: hreadyout=1, hresp=0, hrdata=0, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0.
- Reset mid-transfer aborts the transfer with no completion; psel/penable are 0 after the reset edge.
- Accept condition: hsel & hready_in & htrans[1] while state is IDLE or ERR2. On accept, register haddr[APB_AW-1:0] and hwrite. htrans IDLE/BUSY gets a zero-wait OKAY and no APB activity.
- hsize, hburst and hprot are not ported; every transfer is treated as a full DW-bit word.
- States:
  - IDLE: hreadyout=1, hresp=0, psel=0. On accept: write -> WDATA; read -> SETUP.
  - WDATA: one cycle; hreadyout=0; capture hwdata into pwdata; -> SETUP.
  - SETUP: psel=1, penable=0; paddr/pwrite/pwdata driven from registers; hreadyout=0; -> ACCESS unconditionally.
  - ACCESS: psel=1, penable=1; hreadyout=0. paddr/pwrite/pwdata held stable.
    - pready=0: stay in ACCESS, no limit on wait states.
    - pready=1 and pslverr=0: -> IDLE. Registers hrdata=prdata on reads; hrdata holds its value on writes. IDLE then completes the data phase with hreadyout=1.
    - pready=1 and pslverr=1: -> ERR1.
  - ERR1: psel=0, hreadyout=0, hresp=1; -> ERR2.
  - ERR2: hreadyout=1, hresp=1. A transfer may be accepted here, with the same next-state rule as IDLE; otherwise -> IDLE.
- psel and penable drop to 0 in the cycle after pready=1 is sampled in ACCESS. There is no back-to-back APB transfer without passing IDLE or ERR2.
- Latency, from the AHB address-phase cycle T0 to the data phase completing with hreadyout=1, with zero APB wait states:
  - read: SETUP at T1, ACCESS at T2, done at T3.
  - write: WDATA at T1, SETUP at T2, ACCESS at T3, done at T4.
  - each APB wait state adds one cycle.
- Pipelining: the next address phase is accepted in the cycle its predecessor completes (IDLE with hreadyout=1).
- Address truncation: haddr bits above APB_AW are dropped; no decode is done.
- prdata is ignored on writes and pwdata is don't-care on reads; pwdata holds its last written value.
- pslverr is only sampled in ACCESS with pready=1.

Test Plan:
- Single read, haddr=0x0000_0040, pready=1 immediately, prdata=0xDEAD_BEEF -> psel rises at T1, penable at T2, paddr=0x40, pwrite=0; hreadyout=1 with hrdata=0xDEAD_BEEF and hresp=0 at T3.
- Single write, haddr=0x10, hwdata=0x1234_5678, pready held low 3 cycles -> pwrite=1, pwdata=0x1234_5678, paddr stable through ACCESS; hreadyout=0 for 6 cycles; OKAY at T7.
- Read with pready=1 and pslverr=1 -> ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1), then IDLE with hresp=0.
- Back-to-back write 0x20 then read 0x24, second address presented in the first transfer's completion cycle -> two distinct APB transfers, psel low for exactly 1 cycle between them, correct data on both.
- htrans=IDLE with hsel=1, and hsel=0 with htrans=NONSEQ -> no psel, hreadyout stays 1, hresp=0.
- reset_n driven low during ACCESS with pready=0 -> next edge: psel=0, penable=0, hreadyout=1, hresp=0, hrdata=0; a following read completes normally.

Source files
------------

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB master bridge. Each accepted AHB single transfer becomes
// one APB SETUP/ACCESS sequence, with the AHB data phase stalled until it completes.
module ahb2apb_bridge #(
    parameter int AHB_AW = 32,
    parameter int APB_AW = 32,
    parameter int DW     = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              hsel,
    input  logic [AHB_AW-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [DW-1:0]     hwdata,
    input  logic              hready_in,
    output logic              hreadyout,
    output logic [DW-1:0]     hrdata,
    output logic              hresp,
    output logic [APB_AW-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DW-1:0]     pwdata,
    input  logic [DW-1:0]     prdata,
    input  logic              pready,
    input  logic              pslverr
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WDATA  = 3'd1,
        SETUP  = 3'd2,
        ACCESS = 3'd3,
        ERR1   = 3'd4,
        ERR2   = 3'd5
    } state_t;

    state_t state, state_nxt;
    logic   accept;
    logic   unused_htrans0;

    assign unused_htrans0 = htrans[0];

    // Upper address bits are simply dropped; the bridge does no decode.
    generate
        if (AHB_AW > APB_AW) begin : g_trunc
            logic unused_haddr_hi;
            assign unused_haddr_hi = ^haddr[AHB_AW-1:APB_AW];
        end
    endgenerate

    assign accept = hsel & hready_in & htrans[1] & ((state == IDLE) | (state == ERR2));

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        hreadyout = 1'b0;
        hresp     = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;
        case (state)
            IDLE, ERR2: begin
                hreadyout = 1'b1;
                hresp     = (state == ERR2);
                if (accept) state_nxt = hwrite ? WDATA : SETUP;
                else        state_nxt = IDLE;
            end
            WDATA: state_nxt = SETUP;
            SETUP: begin
                psel      = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pready) state_nxt = pslverr ? ERR1 : IDLE;
            end
            ERR1: begin
                hresp     = 1'b1;
                state_nxt = ERR2;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address/direction are latched at accept and held for the whole APB sequence.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            paddr  <= '0;
            pwrite <= 1'b0;
            pwdata <= '0;
            hrdata <= '0;
        end else begin
            if (accept) begin
                paddr  <= haddr[APB_AW-1:0];
                pwrite <= hwrite;
            end
            if (state == WDATA) pwdata <= hwdata;
            if ((state == ACCESS) && pready && !pslverr && !pwrite) hrdata <= prdata;
        end
    end

endmodule
